// File: rtl/dc_token_ring_writer.sv
// Write end of a token-ring dual-clock channel: slot buffer, one-hot write
// token, read-pointer synchroniser. Optional level_o via DC_TOKEN_WRITER_LEVEL_EN.
module dc_token_ring_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_WIDTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [DATA_WIDTH-1:0]              data_i,
  output logic [BUFFER_WIDTH-1:0]            writetoken_o,
  output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_o,
  input  logic [BUFFER_WIDTH-1:0]            readpointer_i,
  output logic                               empty_o
`ifdef DC_TOKEN_WRITER_LEVEL_EN
  ,
  output logic [$clog2(BUFFER_WIDTH):0]      level_o
`endif
);

  localparam logic [BUFFER_WIDTH-1:0] ONE =
    {{(BUFFER_WIDTH-1){1'b0}}, 1'b1};

  logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_WIDTH-1:0] rsync;
  logic [BUFFER_WIDTH-1:0] token_q;
  logic [BUFFER_WIDTH-1:0] token_nxt;
  logic                    full;
  logic                    accept;

  assign rsync     = sync_q[SYNC_STAGES-1];
  assign token_nxt = {token_q[BUFFER_WIDTH-2:0],
                      token_q[BUFFER_WIDTH-1]};
  // Pointer one ahead of the token held by the reader means one free slot left.
  assign full      = |(token_nxt & rsync);
  assign accept    = valid_i & ~full;

  assign ready_o      = ~full;
  assign empty_o      = (rsync == token_q);
  assign writetoken_o = token_q;

  // Bitwise synchroniser for the remote read pointer; resets to slot 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= ONE;
    end else begin
      sync_q[0] <= readpointer_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Write token rotates by one slot per accepted word.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      token_q <= ONE;
    else if (accept)
      token_q <= token_nxt;
  end

  // Only the slot selected by the token is written, on the token-move edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_async_o <= '0;
    end else begin
      for (int k = 0; k < BUFFER_WIDTH; k++)
        if (accept && token_q[k])
          data_async_o[k*DATA_WIDTH +: DATA_WIDTH] <= data_i;
    end
  end

`ifdef DC_TOKEN_WRITER_LEVEL_EN
  localparam int IW = $clog2(BUFFER_WIDTH);
  localparam logic [IW:0] BW_L = (IW+1)'(BUFFER_WIDTH);

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW:0]   level_d;
  logic [IW:0]   level_q;
  logic          rd_onehot;

  // Occupancy from token/pointer indices, modulo the ring size.
  always_comb begin
    wr_idx = '0;
    rd_idx = '0;
    for (int k = 0; k < BUFFER_WIDTH; k++) begin
      if (token_q[k]) wr_idx = IW'(k);
      if (rsync[k])   rd_idx = IW'(k);
    end
    rd_onehot = $onehot(rsync);
    if (wr_idx >= rd_idx)
      level_d = {1'b0, wr_idx} - {1'b0, rd_idx};
    else
      level_d = {1'b0, wr_idx} + BW_L - {1'b0, rd_idx};
  end

  // Hold the last good level while the pointer is mid-transition.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      level_q <= '0;
    else if (rd_onehot)
      level_q <= level_d;
  end

  assign level_o = level_q;
`endif

endmodule

// File: tb/tb_dc_token_ring_writer.sv
// Directed bench for dc_token_ring_writer with a slot scoreboard
// and a cycle model of token, synchroniser and full/empty.
module tb_dc_token_ring_writer;

  localparam int DW = 32;
  localparam int BW = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic           valid;
  logic           ready;
  logic [DW-1:0]  din;
  logic [BW-1:0]  tok;
  logic [BW*DW-1:0] dout;
  logic [BW-1:0]  rp;
  logic           empty;
`ifdef DC_TOKEN_WRITER_LEVEL_EN
  logic [3:0]     level;
`endif

  always #5 clk = ~clk;

  dc_token_ring_writer #(
    .DATA_WIDTH  (DW),
    .BUFFER_WIDTH(BW),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .valid_i      (valid),
    .ready_o      (ready),
    .data_i       (din),
    .writetoken_o (tok),
    .data_async_o (dout),
    .readpointer_i(rp),
    .empty_o      (empty)
`ifdef DC_TOKEN_WRITER_LEVEL_EN
    ,
    .level_o      (level)
`endif
  );

  typedef struct packed {
    logic [2:0]    idx;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [BW-1:0]    m_tok;
  logic [BW-1:0]    m_s1;
  logic [BW-1:0]    m_s2;
  logic [BW*DW-1:0] m_data;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return ~|({m_tok[BW-2:0], m_tok[BW-1]} & m_s2);
  endfunction

  task automatic step();
    logic acc;
    logic [2:0] idx;
    ent_t e;
    acc = valid && m_ready();
    @(posedge clk);
    m_s2 = m_s1;
    m_s1 = rp;
    if (acc) begin
      idx = '0;
      for (int k = 0; k < BW; k++)
        if (m_tok[k]) idx = 3'(k);
      sb.push_back('{idx: idx, d: din});
      m_data[idx*DW +: DW] = din;
      m_tok = {m_tok[BW-2:0], m_tok[BW-1]};
    end
    #1;
    if (acc) valid = 1'b0;
    chk("ready", 256'(ready), 256'(m_ready()));
    chk("token", 256'(tok), 256'(m_tok));
    chk("empty", 256'(empty), 256'(m_s2 == m_tok));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("slot", 256'(dout[e.idx*DW +: DW]), 256'(e.d));
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_tok  = 8'h01;
    m_s1   = 8'h01;
    m_s2   = 8'h01;
    m_data = '0;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    valid = 1'b0;
    rp    = 8'h01;
    model_reset();
    @(negedge clk);
    #2;
    rstn = 1'b1;
    #1;
  endtask

  task automatic fill7(input logic [DW-1:0] base);
    for (int i = 0; i < 7; i++) begin
      valid = 1'b1;
      din   = base + DW'(i);
      step();
    end
  endtask

  initial begin
    rstn  = 1'b0;
    valid = 1'b0;
    din   = '0;
    rp    = 8'h01;
    model_reset();
    #23;
    rstn = 1'b1;
    #1;
    chk("rst_token", 256'(tok), 256'(8'h01));
    chk("rst_ready", 256'(ready), 256'(1'b1));
    chk("rst_empty", 256'(empty), 256'(1'b1));
    chk("rst_data", 256'(dout), 256'(0));
    step();

    fill7(32'hA0);
    chk("full_token", 256'(tok), 256'(8'h80));
    chk("full_ready", 256'(ready), 256'(1'b0));
    valid = 1'b1;
    din   = 32'hA7;
    step();
    step();
    chk("hold_token", 256'(tok), 256'(8'h80));
    chk("hold_slot7", 256'(dout[7*DW +: DW]), 256'(0));
    chk("hold_all", 256'(dout), 256'(m_data));

    rp = 8'h02;
    step();
    chk("rp_1edge", 256'(ready), 256'(1'b0));
    step();
    chk("rp_2edge", 256'(ready), 256'(1'b1));
    step();
    chk("wrap_token", 256'(tok), 256'(8'h01));
    chk("wrap_slot7", 256'(dout[7*DW +: DW]), 256'(32'hA7));
    chk("wrap_all", 256'(dout), 256'(m_data));

    do_reset();
    chk("rst2_data", 256'(dout), 256'(0));
    fill7(32'hB0);
    valid = 1'b1;
    din   = 32'hB7;
    rp    = 8'h03;
    step();
    rp = 8'h00;
    step();
    rp = 8'h02;
    for (int i = 0; i < 4; i++) step();
    chk("glitch_token", 256'(tok), 256'(8'h01));
    chk("glitch_slot7", 256'(dout[7*DW +: DW]), 256'(32'hB7));
    chk("glitch_slot0", 256'(dout[0 +: DW]), 256'(32'hB0));
    chk("glitch_all", 256'(dout), 256'(m_data));

    do_reset();
    valid = 1'b1;
    din   = 32'hC0;
    step();
    valid = 1'b1;
    din   = 32'hC1;
    step();
    valid = 1'b1;
    din   = 32'hC2;
    #3;
    rstn  = 1'b0;
    valid = 1'b0;
    rp    = 8'h01;
    model_reset();
    #1;
    chk("async_token", 256'(tok), 256'(8'h01));
    chk("async_data", 256'(dout), 256'(0));
    #2;
    rstn = 1'b1;
    #1;
    chk("post_ready", 256'(ready), 256'(1'b1));
    chk("post_empty", 256'(empty), 256'(1'b1));
    step();

`ifdef DC_TOKEN_WRITER_LEVEL_EN
    do_reset();
    chk("lvl_rst", 256'(level), 256'(0));
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      din   = 32'hD0 + DW'(i);
      step();
    end
    step();
    chk("lvl_3", 256'(level), 256'(3));
    rp = 8'h04;
    step();
    step();
    chk("lvl_hold", 256'(level), 256'(3));
    step();
    chk("lvl_1", 256'(level), 256'(1));
`endif

    if (failed != 0)
      $display("comparisons in error: %0d", failed);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
